// File: rtl/cordic_arbiter.sv
// Round-robin front end that time-shares one iterative CORDIC sin/cos core
// between NUM_REQ requesters and returns each result tagged with its requester ID.
module cordic_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 31,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_angle,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   core_start,
  output logic [31:0]            core_angle,
  input  logic [31:0]            core_sin,
  input  logic [31:0]            core_cos,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_sin,
  output logic [31:0]            rsp_cos,
  output logic                   busy
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       core_angle_q, core_angle_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_sin_q, rsp_sin_d;
  logic [31:0]       rsp_cos_q, rsp_cos_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic [ID_W:0]     next_ptr;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
    next_ptr = {1'b0, grant_idx} + (ID_W+1)'(1);
    if (next_ptr >= (ID_W+1)'(NUM_REQ)) next_ptr = '0;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a requester holds its angle
  // until it sees its ready bit.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    core_angle_d = core_angle_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sin_d    = rsp_sin_q;
    rsp_cos_d    = rsp_cos_q;
    req_ready    = '0;
    core_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          core_angle_d         = req_angle[32*int'(grant_idx) +: 32];
          id_d                 = grant_idx;
          rr_ptr_d             = next_ptr[ID_W-1:0];
          state_d              = START;
        end
      end
      START: begin
        core_start = 1'b1;
        cnt_d      = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_W'(LATENCY)) begin
          rsp_sin_d   = core_sin;
          rsp_cos_d   = core_cos;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Combinational outputs are forced quiet while reset is sampled.
    if (rst) begin
      req_ready  = '0;
      core_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      core_angle_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sin_q    <= '0;
      rsp_cos_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      core_angle_q <= core_angle_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sin_q    <= rsp_sin_d;
      rsp_cos_q    <= rsp_cos_d;
    end
  end

  assign core_angle = core_angle_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sin    = rsp_sin_q;
  assign rsp_cos    = rsp_cos_q;
  assign busy       = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stub core, timeline model of each transaction,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_cordic_arbiter;

  localparam int N   = 4;
  localparam int LAT = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_angle;
  logic [N-1:0]    req_ready;
  logic            core_start;
  logic [31:0]     core_angle, core_sin, core_cos;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_sin, rsp_cos;
  logic            busy;

  cordic_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .core_start(core_start), .core_angle(core_angle),
    .core_sin(core_sin), .core_cos(core_cos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .busy(busy)
  );

  // ---------------- stub core ----------------
  // Iteration index restarts on a sampled start; outputs follow the angle combinationally.
  function automatic logic [31:0] stub_sin(input logic [31:0] a, input logic [7:0] it);
    return a ^ {it, 24'h000000};
  endfunction
  function automatic logic [31:0] stub_cos(input logic [31:0] a, input logic [7:0] it);
    return ~a + {24'h000000, it};
  endfunction

  logic [7:0] stub_it = 8'h00;
  always @(posedge clk) begin
    if (core_start) stub_it <= 8'h00;
    else if (stub_it != 8'hFF) stub_it <= stub_it + 8'h01;
  end
  assign core_sin = stub_sin(core_angle, stub_it);
  assign core_cos = stub_cos(core_angle, stub_it);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // ---------------- transaction timeline model ----------------
  int          edge_n = 0;
  bit          m_init = 1'b0;
  bit          m_active = 1'b0;
  bit          m_resp = 1'b0;
  int          m_t0 = 0;
  int          m_rr = 0;
  logic [1:0]  m_id = '0;
  logic [31:0] m_angle = '0, m_sin = '0, m_cos = '0;
  logic [1:0]  m_rsp_id = '0;

  always @(posedge clk) begin
    int g;
    edge_n++;
    if (rst) begin
      m_init = 1'b1; m_active = 1'b0; m_resp = 1'b0; m_rr = 0;
      m_angle = '0; m_sin = '0; m_cos = '0; m_rsp_id = '0;
    end else if (m_init) begin
      if (!m_active) begin
        g = rr_pick(m_rr, req_valid);
        if (g >= 0) begin
          m_active = 1'b1;
          m_t0     = edge_n;
          m_id     = g[1:0];
          m_angle  = req_angle[32*g +: 32];
          m_rr     = (g + 1) % N;
        end
      end else if (!m_resp) begin
        if (edge_n - m_t0 == LAT + 2) begin
          m_resp   = 1'b1;
          m_sin    = stub_sin(m_angle, 8'(LAT));
          m_cos    = stub_cos(m_angle, 8'(LAT));
          m_rsp_id = m_id;
        end
      end else if (rsp_ready) begin
        m_active = 1'b0;
        m_resp   = 1'b0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0] er;
    int g;
    if (m_init) begin
      if (rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_req_ready", req_ready, 0);
      end else begin
        er = '0;
        if (!m_active) begin
          g = rr_pick(m_rr, req_valid);
          if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_active);
        chk("core_start", core_start, m_active && !m_resp && (edge_n == m_t0));
        chk("core_angle", core_angle, m_angle);
        chk("rsp_valid", rsp_valid, m_resp);
        chk("rsp_id", rsp_id, m_rsp_id);
        chk("rsp_sin", rsp_sin, m_sin);
        chk("rsp_cos", rsp_cos, m_cos);
      end
    end
  end

  // Response ID order, used by the round-robin scenario.
  always @(negedge clk) begin
    logic [1:0] e;
    if (m_init && !rst && rsp_valid && rsp_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rr_rsp_id", rsp_id, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [31:0] a, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    req_angle[32*k +: 32] = a;
    req_valid[k] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        got = 1'b1;
        acc = edge_n + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    chk("send_accepted", got, 1);
  endtask

  task automatic wait_rsp(output int e);
    bit got;
    got = 1'b0;
    e = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        e = edge_n;
        break;
      end
    end
    chk("rsp_arrived", got, 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy === 1'b0) break;
    end
    chk("returned_idle", busy, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int acc, acc2, e, hs, nacc;
    rst = 1'b1; req_valid = '0; req_angle = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_core_angle", core_angle, 0);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_rsp_sin", rsp_sin, 0);
    tick();

    // Reset in the middle of RUN at cnt=10.
    send(0, 32'h3E800000, acc);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_core_start", core_start, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_core_angle", core_angle, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_rsp_cos", rsp_cos, 0);
    tick();

    // Requester 1 with a negative angle that it changes right after acceptance.
    send(1, 32'hBF800000, acc);
    req_angle[63:32] = 32'h12345678;
    wait_rsp(e);
    chk("neg_core_angle", core_angle, 32'hBF800000);
    chk("neg_rsp_id", rsp_id, 1);
    chk("neg_rsp_sin", rsp_sin, 32'hA0800000);
    chk("neg_rsp_cos", rsp_cos, 32'h4080001E);
    wait_idle();

    // Single request, pi/4.
    send(0, 32'h3F490FDB, acc);
    wait_rsp(e);
    chk("single_latency", e - acc, 33);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_rsp_sin", rsp_sin, 32'h20490FDB);
    chk("single_rsp_cos", rsp_cos, 32'hC0B6F043);
    tick();
    @(negedge clk);
    chk("single_rsp_one_cycle", rsp_valid, 0);
    tick();

    // Round robin with all four requesters held valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_angle = {32'h40000003, 32'h40000002, 32'h40000001, 32'h40000000};
    req_valid = 4'hF;
    nacc = 0;
    for (int c = 0; c < 400 && nacc < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) nacc++;
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("rr_accepts", nacc, 5);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) tick();
    chk("rr_ids_left", exp_q.size(), 0);
    wait_idle();

    // Backpressure with requester 2 waiting.
    rsp_ready = 1'b0;
    send(3, 32'h40490FDB, acc);
    hs = -1;
    fork
      send(2, 32'h3F800000, acc2);
      begin
        wait_rsp(e);
        repeat (20) begin
          @(negedge clk);
          chk("bp_rsp_id", rsp_id, 3);
          chk("bp_rsp_sin", rsp_sin, 32'h5F490FDB);
          chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        hs = edge_n + 1;
      end
    join
    chk("bp_accept_gap", acc2 - hs, 1);
    wait_rsp(e);
    chk("bp_req2_rsp_id", rsp_id, 2);
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
